// File: rtl/keyreg_multi_if.sv
// Keypad-side bus for keyreg_multi: key strobe/edit controls in, digit buffer and status out.
interface keyreg_multi_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DW     = 4
);
   localparam int unsigned CW = $clog2(DIGITS + 1);

   logic [DW-1:0]        key;
   logic                 shift;
   logic                 backspace;
   logic                 clear;
   logic [DIGITS*DW-1:0] key_buffer;
   logic [CW-1:0]        digit_count;
   logic                 full;
   logic                 entry_active;
   logic                 timeout;

   modport master (
      output key, shift, backspace, clear,
      input  key_buffer, digit_count, full, entry_active, timeout
   );

   modport slave (
      input  key, shift, backspace, clear,
      output key_buffer, digit_count, full, entry_active, timeout
   );
endinterface

// File: rtl/keyreg_multi.sv
// Parametrised keypad entry buffer: keys shift in at slot 0, with backspace, clear,
// digit count, full flag, optional wrap and an inactivity auto-clear.
module keyreg_multi #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned DW          = 4,
   parameter int unsigned KEY_MAX     = 9,
   parameter int unsigned BLANK       = 0,
   parameter bit          WRAP        = 1'b0,
   parameter int unsigned TIMEOUT_CYC = 2500
) (
   input  logic          clk_i,
   input  logic          rst_i,
   keyreg_multi_if.slave bus
);
   localparam int unsigned CW  = $clog2(DIGITS + 1);
   localparam int unsigned TCW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [TCW-1:0] TMAX  = TCW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [CW-1:0]  CFULL = CW'(DIGITS);
   localparam logic [DW-1:0]  BLK   = DW'(BLANK);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_FULL
   } state_e;

   state_e                    state_q, state_d;
   logic [DIGITS-1:0][DW-1:0] slot_q, slot_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [TCW-1:0]            idle_q, idle_d;
   logic                      to_q, to_d;
   logic                      full_q, full_d;
   logic                      act_q, act_d;
   logic                      key_ok;

   assign key_ok = (32'(bus.key) <= KEY_MAX);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         for (int i = 0; i < int'(DIGITS); i++) slot_q[i] <= BLK;
         cnt_q   <= '0;
         idle_q  <= '0;
         to_q    <= 1'b0;
         full_q  <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         to_q    <= to_d;
         full_q  <= full_d;
         act_q   <= act_d;
      end
   end

   // Priority: clear > backspace > shift > inactivity timeout.
   always_comb begin
      slot_d  = slot_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      to_d    = 1'b0;
      state_d = state_q;
      if (bus.clear) begin
         for (int i = 0; i < int'(DIGITS); i++) slot_d[i] = BLK;
         cnt_d  = '0;
         idle_d = '0;
      end else if (bus.backspace) begin
         idle_d = '0;
         if (cnt_q != '0) begin
            for (int i = 0; i < int'(DIGITS) - 1; i++) slot_d[i] = slot_q[i+1];
            slot_d[DIGITS-1] = BLK;
            cnt_d = cnt_q - CW'(1);
         end
      end else if (bus.shift) begin
         idle_d = '0;
         if (key_ok && (cnt_q != CFULL || WRAP)) begin
            for (int i = int'(DIGITS) - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            slot_d[0] = bus.key;
            if (cnt_q != CFULL) cnt_d = cnt_q + CW'(1);
         end
      end else if (state_q != S_IDLE && TIMEOUT_CYC != 0) begin
         if (idle_q == TMAX) begin
            for (int i = 0; i < int'(DIGITS); i++) slot_d[i] = BLK;
            cnt_d = '0;
            to_d  = 1'b1;
         end else begin
            idle_d = idle_q + TCW'(1);
         end
      end

      // State follows the post-update digit count.
      if (cnt_d == '0)        state_d = S_IDLE;
      else if (cnt_d == CFULL) state_d = S_FULL;
      else                    state_d = S_ENTRY;

      if (state_d == S_IDLE) idle_d = '0;
   end

   assign full_d = (state_d == S_FULL);
   assign act_d  = (state_d != S_IDLE);

   assign bus.key_buffer   = slot_q;
   assign bus.digit_count  = cnt_q;
   assign bus.full         = full_q;
   assign bus.entry_active = act_q;
   assign bus.timeout      = to_q;

   a_cnt_range : assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CFULL);
   a_full_cnt  : assert property (@(posedge clk_i) disable iff (rst_i) full_q == (cnt_q == CFULL));
   a_to_pulse  : assert property (@(posedge clk_i) disable iff (rst_i) to_q |=> !to_q);
endmodule

// File: tb/tb_keyreg_multi.sv
// Scoreboard bench: two instances (no-wrap with 10-cycle timeout, wrap without timeout)
// driven in lockstep; expected outputs are queued per stimulus cycle and checked by a monitor.
module tb_keyreg_multi;
   logic clk;
   logic rst;

   keyreg_multi_if #(.DIGITS(4), .DW(4)) bus_a ();
   keyreg_multi_if #(.DIGITS(4), .DW(4)) bus_b ();

   keyreg_multi #(
      .DIGITS(4), .DW(4), .KEY_MAX(9), .BLANK(0), .WRAP(1'b0), .TIMEOUT_CYC(10)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .bus(bus_a.slave)
   );

   keyreg_multi #(
      .DIGITS(4), .DW(4), .KEY_MAX(9), .BLANK(0), .WRAP(1'b1), .TIMEOUT_CYC(0)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .bus(bus_b.slave)
   );

   typedef struct {
      int          id;
      logic [15:0] buf_a;
      logic [2:0]  cnt_a;
      logic        to_a;
      logic [15:0] buf_b;
      logic [2:0]  cnt_b;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   step_id = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int id, input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, id, got, want);
      end
   endtask

   // Monitor: every cycle the design presents a fresh registered result.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("a_buf",    e.id, 32'(bus_a.key_buffer),   32'(e.buf_a));
            check("a_cnt",    e.id, 32'(bus_a.digit_count),  32'(e.cnt_a));
            check("a_full",   e.id, 32'(bus_a.full),         32'(e.cnt_a == 3'd4));
            check("a_active", e.id, 32'(bus_a.entry_active), 32'(e.cnt_a != 3'd0));
            check("a_tout",   e.id, 32'(bus_a.timeout),      32'(e.to_a));
            check("b_buf",    e.id, 32'(bus_b.key_buffer),   32'(e.buf_b));
            check("b_cnt",    e.id, 32'(bus_b.digit_count),  32'(e.cnt_b));
            check("b_full",   e.id, 32'(bus_b.full),         32'(e.cnt_b == 3'd4));
            check("b_tout",   e.id, 32'(bus_b.timeout),      32'd0);
         end
      end
   end

   // One stimulus cycle plus the outputs expected right after its sampling edge.
   task automatic step(input logic r, input logic [3:0] k, input logic sh, input logic bs,
                       input logic cl, input logic [15:0] ba, input logic [2:0] ca,
                       input logic ta, input logic [15:0] bb, input logic [2:0] cb);
      exp_t e;
      @(negedge clk);
      rst = r;
      bus_a.key = k;  bus_a.shift = sh;  bus_a.backspace = bs;  bus_a.clear = cl;
      bus_b.key = k;  bus_b.shift = sh;  bus_b.backspace = bs;  bus_b.clear = cl;
      step_id++;
      e.id = step_id;
      e.buf_a = ba; e.cnt_a = ca; e.to_a = ta; e.buf_b = bb; e.cnt_b = cb;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      bus_a.key = '0; bus_a.shift = 1'b0; bus_a.backspace = 1'b0; bus_a.clear = 1'b0;
      bus_b.key = '0; bus_b.shift = 1'b0; bus_b.backspace = 1'b0; bus_b.clear = 1'b0;

      //    rst key sh bs cl  bufA      cA  to  bufB      cB
      step(1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
      step(0, 3, 1, 0, 0, 16'h0003, 1, 0, 16'h0003, 1);
      step(0, 6, 1, 0, 0, 16'h0036, 2, 0, 16'h0036, 2);
      step(0, 1, 1, 0, 0, 16'h0361, 3, 0, 16'h0361, 3);
      step(0, 2, 1, 0, 0, 16'h3612, 4, 0, 16'h3612, 4);
      // key while full: no-wrap holds, wrap drops MS digit
      step(0, 5, 1, 0, 0, 16'h3612, 4, 0, 16'h6125, 4);
      step(0, 0, 0, 1, 0, 16'h0361, 3, 0, 16'h0612, 3);
      step(0, 0, 0, 1, 0, 16'h0036, 2, 0, 16'h0061, 2);
      step(0, 0, 0, 1, 0, 16'h0003, 1, 0, 16'h0006, 1);
      step(0, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0);
      step(0, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0);
      // out-of-range key, then priority combinations
      step(0, 12, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
      step(0, 7, 1, 0, 0, 16'h0007, 1, 0, 16'h0007, 1);
      step(0, 8, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0);
      step(0, 4, 1, 0, 0, 16'h0004, 1, 0, 16'h0004, 1);
      step(0, 2, 1, 0, 0, 16'h0042, 2, 0, 16'h0042, 2);
      step(0, 9, 1, 1, 1, 16'h0000, 0, 0, 16'h0000, 0);
      // inactivity: pulse appears 10 cycles after the last key
      step(0, 5, 1, 0, 0, 16'h0005, 1, 0, 16'h0005, 1);
      step(0, 8, 1, 0, 0, 16'h0058, 2, 0, 16'h0058, 2);
      for (int k = 1; k <= 12; k++) begin
         step(0, 0, 0, 0, 0,
              (k >= 10) ? 16'h0000 : 16'h0058, (k >= 10) ? 3'd0 : 3'd2, (k == 10),
              16'h0058, 3'd2);
      end
      // reset mid-entry, then a fresh key lands in slot 0
      step(0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0);
      step(0, 3, 1, 0, 0, 16'h0003, 1, 0, 16'h0003, 1);
      step(0, 6, 1, 0, 0, 16'h0036, 2, 0, 16'h0036, 2);
      step(1, 9, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
      step(0, 7, 1, 0, 0, 16'h0007, 1, 0, 16'h0007, 1);
      step(0, 0, 0, 0, 0, 16'h0007, 1, 0, 16'h0007, 1);

      begin : drain
         int waited;
         waited = 0;
         while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
         end
         #2;
         if (exp_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
         end
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
